// File: rtl/cdc_sync_pkg.sv
// Shared definitions for the CDC synchronizer bank: minimum chain depth,
// filter counter sizing and the bypass/filter mode tag.
package cdc_sync_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    typedef enum logic {
        SYNC_BYPASS,
        SYNC_FILTER
    } sync_mode_e;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: stability filter counter, o_q register and edge-pulse registers.
// Latency: 1 edge (bypass) or FILT_CYC edges after the sync bit settles; no backpressure.
// Edge registers exist only with MULTI_STAGE_SYNC_BANK_EDGE_EN defined.
module sync_filter_ch
    import cdc_sync_pkg::*;
#(
    parameter int FILT_CYC = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sync,
    input  logic i_rst_val,
    output logic o_q
`ifdef MULTI_STAGE_SYNC_BANK_EDGE_EN
    ,
    output logic o_rise,
    output logic o_fall,
    output logic o_chg_nxt
`endif
);

    localparam int CNT_W = cnt_width(FILT_CYC);

    logic r_q;
    logic w_q_nxt;

    // In bypass mode r_q acts as the final synchronizer stage.
    generate
        if (FILT_CYC == 0) begin : g_byp
            assign w_q_nxt = i_sync;
        end else begin : g_filt
            localparam logic [CNT_W-1:0] LAST = CNT_W'(FILT_CYC - 1);
            logic [CNT_W-1:0] r_cnt;
            logic             w_diff;
            logic             w_take;

            assign w_diff  = (i_sync != r_q);
            assign w_take  = w_diff && (r_cnt == LAST);
            assign w_q_nxt = w_take ? i_sync : r_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (!w_diff || w_take) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= i_rst_val;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    assign o_q = r_q;

`ifdef MULTI_STAGE_SYNC_BANK_EDGE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_q_nxt & ~r_q;
            r_fall <= ~w_q_nxt & r_q;
        end
    end

    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_chg_nxt = w_q_nxt ^ r_q;
`endif

endmodule

// File: rtl/multi_stage_sync_bank.sv
// Bank of independent single-bit synchronizers with optional glitch filter and edge pulses.
// Latency: STAGES edges (bypass) or STAGES+FILT_CYC edges; no backpressure, levels only.
// Edge outputs are built only when MULTI_STAGE_SYNC_BANK_EDGE_EN is defined, else tied 0.
module multi_stage_sync_bank
    import cdc_sync_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               STAGES   = 2,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               FILT_CYC = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_chg
);

    localparam sync_mode_e MODE  = (FILT_CYC == 0) ? SYNC_BYPASS : SYNC_FILTER;
    // Bypass mode borrows the channel's o_q register as the last chain stage.
    localparam int         CHAIN = (MODE == SYNC_BYPASS) ? STAGES - 1 : STAGES;

    generate
        if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
            $error("multi_stage_sync_bank: STAGES must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_s [CHAIN];
    logic [WIDTH-1:0] w_sy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < CHAIN; j++) begin
                r_s[j] <= RST_VAL;
            end
        end else begin
            r_s[0] <= i_D;
            for (int j = 1; j < CHAIN; j++) begin
                r_s[j] <= r_s[j-1];
            end
        end
    end

    assign w_sy = r_s[CHAIN-1];

`ifdef MULTI_STAGE_SYNC_BANK_EDGE_EN
    logic [WIDTH-1:0] w_chg_nxt;
    logic             r_chg;
`endif

    genvar k;
    generate
        for (k = 0; k < WIDTH; k++) begin : g_ch
            sync_filter_ch #(
                .FILT_CYC (FILT_CYC)
            ) u_ch (
                .i_clk     (i_clk),
                .i_rst_n   (i_rst_n),
                .i_sync    (w_sy[k]),
                .i_rst_val (RST_VAL[k]),
                .o_q       (o_q[k])
`ifdef MULTI_STAGE_SYNC_BANK_EDGE_EN
                ,
                .o_rise    (o_rise[k]),
                .o_fall    (o_fall[k]),
                .o_chg_nxt (w_chg_nxt[k])
`endif
            );
        end
    endgenerate

`ifdef MULTI_STAGE_SYNC_BANK_EDGE_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chg <= 1'b0;
        end else begin
            r_chg <= |w_chg_nxt;
        end
    end

    assign o_chg = r_chg;
`else
    assign o_rise = '0;
    assign o_fall = '0;
    assign o_chg  = 1'b0;
`endif

endmodule

// File: tb/tb_multi_stage_sync_bank.sv
// Bench for multi_stage_sync_bank: table-driven reset/bypass vectors, directed
// latency/glitch/multi-channel/mid-reset sequences, and a randomized history-based model.
module tb_multi_stage_sync_bank;
    import cdc_sync_pkg::*;

`ifdef MULTI_STAGE_SYNC_BANK_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    localparam int NCFG = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Reset-value instance
    logic       rst_a;
    logic [7:0] d_a, q_a, rise_a, fall_a;
    logic       chg_a;

    multi_stage_sync_bank #(
        .WIDTH(8), .STAGES(2), .RST_VAL(8'hA5), .FILT_CYC(0)
    ) u_rst (
        .i_clk(clk), .i_rst_n(rst_a), .i_D(d_a),
        .o_q(q_a), .o_rise(rise_a), .o_fall(fall_a), .o_chg(chg_a)
    );

    // Configs 0..5: STAGES 2/3/4 x FILT 0/3. Config 6: STAGES 2, FILT 4.
    function automatic int cfg_s(input int c);
        return (c == 6) ? 2 : 2 + c / 2;
    endfunction
    function automatic int cfg_n(input int c);
        return (c == 6) ? 4 : (c % 2) * 3;
    endfunction

    logic                 rst_sw;
    logic [7:0]           d_sw;
    logic [NCFG-1:0][7:0] q_sw, rise_sw, fall_sw;
    logic [NCFG-1:0]      chg_sw;

    genvar g;
    generate
        for (g = 0; g < NCFG; g++) begin : g_dut
            multi_stage_sync_bank #(
                .WIDTH(8), .STAGES(cfg_s(g)), .RST_VAL(8'h00), .FILT_CYC(cfg_n(g))
            ) u_dut (
                .i_clk(clk), .i_rst_n(rst_sw), .i_D(d_sw),
                .o_q(q_sw[g]), .o_rise(rise_sw[g]), .o_fall(fall_sw[g]), .o_chg(chg_sw[g])
            );
        end
    endgenerate

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_sw;
        rst_sw = 1'b0;
        d_sw   = 8'h00;
        repeat (3) @(negedge clk);
        rst_sw = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic [7:0] q;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } vec_t;
    vec_t vt [10];

    // Reference model: o_q follows the input history delayed by STAGES; in
    // filter mode a bit flips only after N consecutive opposite synced samples.
    logic [7:0] hist [$];
    logic [7:0] mq [NCFG];

    function automatic logic [7:0] hist_at(input int i);
        return (i < 0) ? 8'h00 : hist[i];
    endfunction

    function automatic logic [7:0] model_q(input int c, input int e, input logic [7:0] q);
        sync_mode_e mode;
        int         s;
        int         n;
        logic [7:0] hi;
        logic [7:0] lo;
        s    = cfg_s(c);
        n    = cfg_n(c);
        mode = (n == 0) ? SYNC_BYPASS : SYNC_FILTER;
        if (mode == SYNC_BYPASS) return hist_at(e - s + 1);
        hi = 8'hFF;
        lo = 8'hFF;
        for (int i = e - s - n + 1; i <= e - s; i++) begin
            hi &= hist_at(i);
            lo &= ~hist_at(i);
        end
        return (q & ~lo) | hi;
    endfunction

    initial begin
        vt[0] = '{8'hFF, 8'hA5, 8'h00, 8'h00, 1'b0};
        vt[1] = '{8'hFF, 8'hFF, 8'h5A, 8'h00, 1'b1};
        vt[2] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0};
        vt[3] = '{8'h00, 8'hFF, 8'h00, 8'h00, 1'b0};
        vt[4] = '{8'h00, 8'h00, 8'h00, 8'hFF, 1'b1};
        vt[5] = '{8'h0F, 8'h00, 8'h00, 8'h00, 1'b0};
        vt[6] = '{8'h0F, 8'h0F, 8'h0F, 8'h00, 1'b1};
        vt[7] = '{8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0};
        vt[8] = '{8'hF0, 8'hF0, 8'hF0, 8'h0F, 1'b1};
        vt[9] = '{8'hF0, 8'hF0, 8'h00, 8'h00, 1'b0};

        rst_a  = 1'b0;
        rst_sw = 1'b0;
        d_a    = 8'hFF;
        d_sw   = 8'h00;

        // Reset hold and release on the RST_VAL=A5 bypass instance
        repeat (3) @(negedge clk);
        chk("rst_q", q_a, 8'hA5);
        chk("rst_rise", rise_a, 8'h00);
        chk("rst_fall", fall_a, 8'h00);
        chk("rst_chg", chg_a, 1'b0);
        rst_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_a = vt[i].d;
            tick();
            chk($sformatf("vec%0d_q", i), q_a, vt[i].q);
            chk($sformatf("vec%0d_rise", i), rise_a, vt[i].rise & {8{EDGE}});
            chk($sformatf("vec%0d_fall", i), fall_a, vt[i].fall & {8{EDGE}});
            chk($sformatf("vec%0d_chg", i), chg_a, vt[i].chg & EDGE);
        end

        // Latency sweep: step bit 0 and watch each config
        reset_sw();
        d_sw = 8'h01;
        for (int c = 1; c <= 12; c++) begin
            tick();
            for (int k = 0; k < 6; k++) begin
                int lat;
                lat = cfg_s(k) + cfg_n(k);
                chk($sformatf("lat_s%0d_n%0d_c%0d_q", cfg_s(k), cfg_n(k), c),
                    q_sw[k], (c >= lat) ? 8'h01 : 8'h00);
                chk($sformatf("lat_s%0d_n%0d_c%0d_rise", cfg_s(k), cfg_n(k), c),
                    rise_sw[k], (c == lat && EDGE) ? 8'h01 : 8'h00);
            end
        end

        // Glitch reject: 3-cycle pulse on bit 2 with FILT_CYC=4
        reset_sw();
        for (int c = 1; c <= 15; c++) begin
            d_sw = (c <= 3) ? 8'h04 : 8'h00;
            tick();
            chk($sformatf("glitch3_c%0d_q", c), q_sw[6], 8'h00);
            chk($sformatf("glitch3_c%0d_edge", c), {rise_sw[6], fall_sw[6]}, 16'h0000);
        end
        // 4-cycle pulse passes and lasts exactly 4 cycles
        for (int c = 1; c <= 14; c++) begin
            d_sw = (c <= 4) ? 8'h04 : 8'h00;
            tick();
            chk($sformatf("pulse4_c%0d_q", c), q_sw[6], (c >= 6 && c <= 9) ? 8'h04 : 8'h00);
            chk($sformatf("pulse4_c%0d_rise", c), rise_sw[6], (c == 6 && EDGE) ? 8'h04 : 8'h00);
            chk($sformatf("pulse4_c%0d_fall", c), fall_sw[6], (c == 10 && EDGE) ? 8'h04 : 8'h00);
        end

        // Multi-channel simultaneous change
        reset_sw();
        for (int c = 1; c <= 9; c++) begin
            d_sw = 8'h81;
            tick();
            chk($sformatf("multi_c%0d_q", c), q_sw[6], (c >= 6) ? 8'h81 : 8'h00);
            chk($sformatf("multi_c%0d_rise", c), rise_sw[6], (c == 6 && EDGE) ? 8'h81 : 8'h00);
            chk($sformatf("multi_c%0d_fall", c), fall_sw[6], 8'h00);
            chk($sformatf("multi_c%0d_chg", c), chg_sw[6], (c == 6) & EDGE);
        end

        // Mid-operation reset while bit 0 filter count is 2
        d_sw = 8'h80;
        repeat (4) tick();
        chk("midrst_pre_q", q_sw[6], 8'h81);
        rst_sw = 1'b0;
        #1;
        chk("midrst_q", q_sw[6], 8'h00);
        chk("midrst_pulses", {rise_sw[6], fall_sw[6], 7'd0, chg_sw[6]}, 24'h0);
        d_sw = 8'h01;
        @(negedge clk);
        tick();
        rst_sw = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("midrst_c%0d_q", c), q_sw[6], (c >= 6) ? 8'h01 : 8'h00);
            chk($sformatf("midrst_c%0d_rise", c), rise_sw[6], (c == 6 && EDGE) ? 8'h01 : 8'h00);
        end

        // Randomized traffic against the history model, all configs
        reset_sw();
        hist.delete();
        for (int c = 0; c < NCFG; c++) mq[c] = 8'h00;
        begin
            logic [7:0]  dv;
            logic [31:0] r;
            logic [7:0]  qn;
            logic [7:0]  er;
            logic [7:0]  ef;
            dv = 8'h00;
            for (int e = 0; e < 300; e++) begin
                r  = $urandom & $urandom & $urandom;
                dv = dv ^ r[7:0];
                d_sw = dv;
                hist.push_back(dv);
                tick();
                for (int c = 0; c < NCFG; c++) begin
                    qn = model_q(c, e, mq[c]);
                    er = EDGE ? (qn & ~mq[c]) : 8'h00;
                    ef = EDGE ? (~qn & mq[c]) : 8'h00;
                    chk($sformatf("rnd_e%0d_cfg%0d_q", e, c), q_sw[c], qn);
                    chk($sformatf("rnd_e%0d_cfg%0d_rise", e, c), rise_sw[c], er);
                    chk($sformatf("rnd_e%0d_cfg%0d_fall", e, c), fall_sw[c], ef);
                    chk($sformatf("rnd_e%0d_cfg%0d_chg", e, c), chg_sw[c], |(er | ef));
                    mq[c] = qn;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_stage_sync_bank.md
Name: multi_stage_sync_bank

Overview:
- Parametrised multi-channel synchronizer bank for asynchronous single-bit level signals entering the i_clk domain. Each channel is independent.
- Each channel has three parts:
  - an N-stage flip-flop synchronizer chain;
  - an optional stability (glitch) filter with a per-channel counter;
  - registered edge pulses.
- Sits at every CDC boundary that carries quasi-static controls, status lines or debounced pins. Not for multi-bit buses whose bits must stay coherent.

Parameters:
- WIDTH, 8: number of independent channels.
- STAGES, 2: synchronizer flops per channel. Legal range is 2 or more; elaboration error if less than 2.
- RST_VAL, '0 (WIDTH bits): per-channel reset value of the sync chain and o_q.
- FILT_CYC, 0: filter length in cycles. 0 bypasses the filter. With N > 0, a new synchronized value must persist N consecutive cycles before o_q takes it.
- CNT_W, $clog2(FILT_CYC+1) with a minimum of 1: localparam, filter counter width.

Ports:
- i_clk, input, 1: sole clock.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_D, input, WIDTH: asynchronous input levels.
- o_q, output, WIDTH: synchronized and filtered levels.
- o_rise, output, WIDTH: one-cycle pulse when o_q[k] goes 0→1.
- o_fall, output, WIDTH: one-cycle pulse when o_q[k] goes 1→0.
- o_chg, output, 1: OR-reduction of (o_rise | o_fall), registered alongside them.

Behaviour:
- Clocking and reset: one clock (i_clk). Reset is asynchronous, active-low (i_rst_n).
- Reset values while i_rst_n is low:
  - all chain stages and o_q = RST_VAL;
  - filter counters = 0;
  - o_rise, o_fall and o_chg = 0.
- Assertion clears immediately, mid-operation included. After deassertion there is no pulse unless o_q later moves away from RST_VAL.
- Chain: s[0] <= i_D[k], then s[j] <= s[j-1]. The synchronized value sy[k] = s[STAGES-1][k].
- FILT_CYC == 0 (bypass):
  - o_q[k] == sy[k];
  - latency from a stable i_D change to o_q is STAGES edges.
- FILT_CYC == N > 0, evaluated on every edge for each channel k:
  - sy == o_q: cnt <= 0.
  - sy != o_q and cnt < N-1: cnt <= cnt+1.
  - sy != o_q and cnt == N-1: o_q <= sy, cnt <= 0.
  - Latency is STAGES+N edges.
  - An excursion of sy lasting fewer than N cycles is rejected: o_q is unchanged, no pulse, and the counter restarts from 0 on the next difference.
- Edge pulses:
  - o_rise[k] / o_fall[k] are registered and asserted in the same cycle the new o_q value first appears. Each lasts exactly one cycle per transition.
  - o_chg is registered with the same timing as o_rise / o_fall.
  - Back-to-back opposite transitions, which need the input to toggle at least every STAGES(+N) cycles, yield consecutive single pulses. rise and fall are never high together on one channel.
- Channels are fully independent. Simultaneous changes on several channels give simultaneous pulses, with o_chg = 1 for that single cycle.
- Wrap-around: counters never exceed N-1. No overflow is possible.

Optional Feature:
- Macro: MULTI_STAGE_SYNC_BANK_EDGE_EN.
- Defined: the o_rise, o_fall and o_chg logic and registers are built as described in Behaviour.
- Undefined:
  - o_rise, o_fall and o_chg are tied to constant 0 and no edge registers are instantiated;
  - the port list is unchanged;
  - o_q behaviour is identical.

Decomposition:
- Package cdc_sync_pkg holds:
  - localparam MIN_SYNC_STAGES = 2;
  - function cnt_width(int n), returning max(1, $clog2(n+1));
  - typedef sync_mode_e {SYNC_BYPASS, SYNC_FILTER}, used by benches and coverage.
- Sub-module sync_filter_ch: one channel's filter counter, o_q register and edge registers.
  - Inputs: i_clk, i_rst_n, sync bit, reset-value bit.
  - Instantiated WIDTH times in a generate loop.
  - The synchronizer chain stays inline in the top as a WIDTH×STAGES register array.

Test Plan:
1. Reset: WIDTH=8, STAGES=2, FILT_CYC=0, RST_VAL=8'hA5.
   - Hold reset and drive i_D=8'hFF → o_q=8'hA5 with all pulses 0.
   - Release reset → o_q=8'hFF exactly 2 edges later; o_rise=8'h5A for one cycle and o_chg=1.
2. Latency sweep: STAGES∈{2,3,4}, FILT_CYC∈{0,3}.
   - Step i_D[0] 0→1 → o_q[0] rises exactly STAGES+FILT_CYC edges later.
   - o_rise[0] is high for 1 cycle, coincident with the rise.
3. Glitch reject: STAGES=2, FILT_CYC=4.
   - 3-cycle high pulse on i_D[2] → o_q[2] stays 0, no pulse.
   - 4-cycle pulse → o_q[2] high for exactly 4 cycles, with o_rise then o_fall once each.
4. Multi-channel: i_D 8'h00→8'h81 on one edge → o_rise=8'h81 in one cycle and o_chg=1 in one cycle. Other bits are quiet.
5. Mid-operation reset: FILT_CYC=4.
   - Assert i_rst_n low while cnt=2 → o_q=RST_VAL immediately and cnt=0.
   - After release, a full STAGES+4 delay is needed before the update.
6. Macro undefined: repeat test 2 → identical o_q timing; o_rise, o_fall and o_chg constant 0 throughout.
